prio_enc_stream: RTL and testbench
==================================

# prio_enc_stream

Sequential, parametrised successor to the 8-bit combinational priority encoder. The block captures a WIDTH-bit request vector through a valid/ready handshake, then emits the index of every set bit, one index per output beat, in priority order, with a last flag on the final beat. It sits between request/flag-collection logic and any consumer that services requests one at a time, such as an interrupt dispatcher or a lane scheduler.

## Interface
- WIDTH, 8: request vector width; legal range 2..64.
- IDX_W, $clog2(WIDTH): index width; derived, not overridden.
- MSB_FIRST, 0: 0 = lowest set index emitted first; 1 = highest set index emitted first.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_vec  in  WIDTH  request vector to enumerate.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept in_vec this cycle.
- out_pos  out  IDX_W  index of the current set bit.
- out_none  out  1  captured vector was all-zero; out_pos = 0.
- out_last  out  1  final beat of the current vector.
- out_valid  out  1  out_pos/out_none/out_last are valid.
- out_ready  in  1  consumer accepts the current beat.
- out_cnt  out  IDX_W+1  popcount of the captured vector. Present only with PRIO_ENC_COUNT_EN.

## Operation
- State: IDLE, EMIT. Shadow register vec_q holds the remaining unserviced bits.
- IDLE: in_ready = 1, out_valid = 0. On in_valid, load vec_q <= in_vec and go to EMIT.
- EMIT: out_valid = 1. out_pos = first set bit of vec_q in MSB_FIRST order.
  - out_none = (vec_q == 0).
  - out_last = vec_q has at most one bit set.
- Beat accepted (out_valid & out_ready), not last: clear bit out_pos in vec_q and stay in EMIT.
- Beat accepted, last: vec_q <= 0 and go to IDLE.
- in_ready in EMIT = out_last & out_ready. This is a combinational path.
  - If in_valid is also high on the last accepted beat, load the new vector and stay in EMIT with no bubble.
- An all-zero vector produces exactly one beat: out_none = 1, out_last = 1, out_pos = 0.
- Outputs hold stable while out_valid & !out_ready. in_vec changes after capture have no effect.
- Reset, including mid-burst: state = IDLE, vec_q = 0, out_valid/out_pos/out_none/out_last/out_cnt = 0, in_ready = 1. The partial burst is discarded.

## Timing
- Capture at rising edge k: first beat has out_valid = 1 in cycle k+1.
- A vector with n set bits takes n beats (1 beat if n = 0) under continuous out_ready.
- Sustained rate: one index per cycle. Back-to-back vectors have no idle cycle.
- All outputs except in_ready are functions of registered state only.

## Configuration
- PRIO_ENC_COUNT_EN defined:
  - out_cnt port exists. It is registered at capture as popcount(in_vec) and stays constant for the whole burst.
  - out_cnt is 0 in IDLE and after reset.
  - An all-ones vector with WIDTH = 64 gives out_cnt = 64.
- PRIO_ENC_COUNT_EN undefined: out_cnt port and popcount logic are absent. All other behaviour is identical.

## Structure
- Package prio_enc_pkg:
  - state enum (IDLE, EMIT);
  - a popcount function;
  - a first-set-index function parametrised on direction.
- Sub-module prio_enc_comb: combinational WIDTH-bit encoder with MSB_FIRST.
  - Outputs the index and an any-set flag.
  - Instantiated once on vec_q; it is the generalisation of the existing 8-bit casez encoder.

## Test plan
- WIDTH = 8, in_vec = 8'b0000_0000, out_ready = 1:
  - exactly one beat, out_none = 1, out_last = 1, out_pos = 0;
  - out_cnt = 0;
  - then return to IDLE.
- in_vec = 8'b1001_0100, out_ready = 1:
  - out_pos = 2, 4, 7 on consecutive cycles, out_last only on 7;
  - out_cnt = 3 on all three beats.
- in_vec = 8'b0000_0011, out_ready held low for 3 cycles: out_pos = 0 and out_last = 0 stay stable. Release gives 0, then 1 with last.
- Back-to-back: 8'h01 is followed by 8'h80 with in_valid high during the last accepted beat.
  - in_ready = 1 that cycle.
  - Next cycle out_pos = 7, with no gap in out_valid.
- MSB_FIRST = 1, in_vec = 8'b1001_0100: out_pos = 7, 4, 2.
- 8'hFF, rst pulsed after the first accepted beat:
  - out_valid = 0, in_ready = 1 immediately;
  - the next vector 8'h10 emits a single beat, out_pos = 4, last.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// ============================================================================
// Module  : prio_enc_pkg
// Purpose : Shared state encoding and bit-scan helpers for prio_enc_stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package prio_enc_pkg;

    localparam int c_MAX_W = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    function automatic int popcount(input logic [c_MAX_W-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < c_MAX_W; i++) begin
            cnt = cnt + int'(vec[i]);
        end
        return cnt;
    endfunction

    // Scan order is chosen so the last hit is the winner in the requested direction.
    function automatic int first_set_idx(input logic [c_MAX_W-1:0] vec, input logic msb_first);
        int idx;
        idx = 0;
        if (msb_first) begin
            for (int i = 0; i < c_MAX_W; i++) begin
                if (vec[i]) idx = i;
            end
        end else begin
            for (int i = c_MAX_W - 1; i >= 0; i--) begin
                if (vec[i]) idx = i;
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc_comb.sv
// ============================================================================
// Module  : prio_enc_comb
// Purpose : Combinational WIDTH-bit priority encoder, direction set by MSB_FIRST.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc_comb
    import prio_enc_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  MSB_FIRST = 0,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    assign idx_o = IDX_W'(first_set_idx(64'(vec_i), MSB_FIRST != 0));
    assign any_o = |vec_i;

endmodule

`default_nettype wire

// File: rtl/prio_enc_stream.sv
// ============================================================================
// Module  : prio_enc_stream
// Purpose : Captures a request vector and streams out one set-bit index per beat.
//           Optional out_cnt popcount port enabled by defining PRIO_ENC_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_enc_stream
    import prio_enc_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  MSB_FIRST = 0,
    localparam int IDX_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_pos,
    output logic             out_none,
    output logic             out_last,
    output logic             out_valid,
`ifdef PRIO_ENC_COUNT_EN
    output logic [IDX_W:0]   out_cnt,
`endif
    input  logic             out_ready
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic [IDX_W-1:0] w_pos;
    logic             w_any;
    logic             w_emit;
    logic             w_single;
    logic             w_accept;
    logic             w_load;
    logic [WIDTH-1:0] w_clr_mask;

    prio_enc_comb #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_enc (
        .vec_i(vec_q),
        .idx_o(w_pos),
        .any_o(w_any)
    );

    assign w_emit     = (state_q == ST_EMIT);
    assign w_single   = ((vec_q & (vec_q - WIDTH'(1))) == '0);
    assign w_clr_mask = WIDTH'(1) << w_pos;

    // vec_q is zero whenever idle, so out_pos needs no extra gating.
    assign out_valid = w_emit;
    assign out_pos   = w_pos;
    assign out_none  = w_emit & ~w_any;
    assign out_last  = w_emit & w_single;

    assign in_ready  = w_emit ? (out_last & out_ready) : 1'b1;
    assign w_accept  = w_emit & out_ready;
    assign w_load    = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        if (w_load) begin
            state_d = ST_EMIT;
            vec_d   = in_vec;
        end else if (w_accept) begin
            if (out_last) begin
                state_d = ST_IDLE;
                vec_d   = '0;
            end else begin
                vec_d = vec_q & ~w_clr_mask;
            end
        end
    end

`ifdef PRIO_ENC_COUNT_EN
    logic [IDX_W:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (w_load) begin
            cnt_d = (IDX_W+1)'(popcount(64'(in_vec)));
        end else if (w_accept && out_last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt = cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prio_enc_stream.sv
// ============================================================================
// Module  : tb_prio_enc_stream
// Purpose : Scoreboard bench for prio_enc_stream (LSB-first and MSB-first).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prio_enc_stream;

    typedef struct packed {
        logic [2:0] pos;
        logic       none;
        logic       last;
        logic [3:0] cnt;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_vec;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out_pos;
    logic       out_none;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_cnt;

    logic [7:0] in_vec_m;
    logic       in_valid_m;
    logic       in_ready_m;
    logic [2:0] out_pos_m;
    logic       out_none_m;
    logic       out_last_m;
    logic       out_valid_m;
    logic       out_ready_m;
    logic [3:0] out_cnt_m;

    beat_t q[$];
    beat_t qm[$];
    int    n_chk = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    prio_enc_stream #(.WIDTH(8), .MSB_FIRST(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vec   (in_vec),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_pos  (out_pos),
        .out_none (out_none),
        .out_last (out_last),
        .out_valid(out_valid),
`ifdef PRIO_ENC_COUNT_EN
        .out_cnt  (out_cnt),
`endif
        .out_ready(out_ready)
    );

    prio_enc_stream #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk      (clk),
        .rst      (rst),
        .in_vec   (in_vec_m),
        .in_valid (in_valid_m),
        .in_ready (in_ready_m),
        .out_pos  (out_pos_m),
        .out_none (out_none_m),
        .out_last (out_last_m),
        .out_valid(out_valid_m),
`ifdef PRIO_ENC_COUNT_EN
        .out_cnt  (out_cnt_m),
`endif
        .out_ready(out_ready_m)
    );

`ifndef PRIO_ENC_COUNT_EN
    assign out_cnt   = 4'd0;
    assign out_cnt_m = 4'd0;
`endif

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_beat(input string tag, input beat_t e, input logic [2:0] pos,
                            input logic none, input logic last, input logic [3:0] cnt);
        chk({tag, "_pos"},  {5'd0, pos}, {5'd0, e.pos});
        chk({tag, "_none"}, {7'd0, none}, {7'd0, e.none});
        chk({tag, "_last"}, {7'd0, last}, {7'd0, e.last});
`ifdef PRIO_ENC_COUNT_EN
        chk({tag, "_cnt"},  {4'd0, cnt}, {4'd0, e.cnt});
`else
        if (cnt != 4'd0) chk({tag, "_cnt"}, {4'd0, cnt}, 8'd0);
`endif
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", {5'd0, out_pos}, 8'hFF);
            end else begin
                cmp_beat("lsb", q.pop_front(), out_pos, out_none, out_last, out_cnt);
            end
        end
        if (!rst && out_valid_m && out_ready_m) begin
            if (qm.size() == 0) begin
                chk("unexpected_beat_m", {5'd0, out_pos_m}, 8'hFF);
            end else begin
                cmp_beat("msb", qm.pop_front(), out_pos_m, out_none_m, out_last_m, out_cnt_m);
            end
        end
    end

    task automatic push(input logic [2:0] pos, input logic none, input logic last,
                        input logic [3:0] cnt);
        q.push_back('{pos: pos, none: none, last: last, cnt: cnt});
    endtask

    // Returns one delta after the capture edge; in_vec is then scrambled.
    task automatic send(input logic [7:0] v);
        bit done;
        done     = 1'b0;
        in_vec   = v;
        in_valid = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 8'd0, 8'd1);
        in_valid = 1'b0;
        in_vec   = 8'h5A;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && (q.size() != 0 || qm.size() != 0); n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_q",  8'(q.size()),  8'd0);
        chk("drain_qm", 8'(qm.size()), 8'd0);
    endtask

    initial begin
        rst         = 1'b1;
        in_vec      = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        in_vec_m    = 8'h00;
        in_valid_m  = 1'b0;
        out_ready_m = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_in_ready",  {7'd0, in_ready},  8'd1);
        chk("rst_out_none",  {7'd0, out_none},  8'd0);
        chk("rst_out_last",  {7'd0, out_last},  8'd0);
        chk("rst_out_pos",   {5'd0, out_pos},   8'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // All-zero vector: a single none/last beat, then idle.
        push(3'd0, 1'b1, 1'b1, 4'd0);
        send(8'h00);
        @(negedge clk);
        chk("zero_first_beat_valid", {7'd0, out_valid}, 8'd1);
        drain();
        @(negedge clk);
        chk("zero_idle_valid", {7'd0, out_valid}, 8'd0);
        chk("zero_idle_ready", {7'd0, in_ready},  8'd1);
        @(posedge clk);
        #1;

        // 1001_0100 on both encoders.
        push(3'd2, 1'b0, 1'b0, 4'd3);
        push(3'd4, 1'b0, 1'b0, 4'd3);
        push(3'd7, 1'b0, 1'b1, 4'd3);
        qm.push_back('{pos: 3'd7, none: 1'b0, last: 1'b0, cnt: 4'd3});
        qm.push_back('{pos: 3'd4, none: 1'b0, last: 1'b0, cnt: 4'd3});
        qm.push_back('{pos: 3'd2, none: 1'b0, last: 1'b1, cnt: 4'd3});
        in_vec_m   = 8'b1001_0100;
        in_valid_m = 1'b1;
        send(8'b1001_0100);
        in_valid_m = 1'b0;
        in_vec_m   = 8'hFF;
        drain();

        // Backpressure: outputs hold while out_ready is low.
        out_ready = 1'b0;
        push(3'd0, 1'b0, 1'b0, 4'd2);
        push(3'd1, 1'b0, 1'b1, 4'd2);
        send(8'b0000_0011);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid",    {7'd0, out_valid}, 8'd1);
            chk("stall_pos",      {5'd0, out_pos},   8'd0);
            chk("stall_last",     {7'd0, out_last},  8'd0);
            chk("stall_in_ready", {7'd0, in_ready},  8'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Back-to-back: 8'h80 captured on the last accepted beat of 8'h01.
        push(3'd0, 1'b0, 1'b1, 4'd1);
        push(3'd7, 1'b0, 1'b1, 4'd1);
        in_vec   = 8'h01;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_vec = 8'h80;
        @(negedge clk);
        chk("b2b_in_ready",  {7'd0, in_ready},  8'd1);
        chk("b2b_valid_1st", {7'd0, out_valid}, 8'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_vec = 8'h3C;
        @(negedge clk);
        chk("b2b_valid_2nd", {7'd0, out_valid}, 8'd1);
        chk("b2b_pos_2nd",   {5'd0, out_pos},   8'd7);
        drain();

        // Reset mid-burst discards the remaining bits of 8'hFF.
        push(3'd0, 1'b0, 1'b0, 4'd8);
        send(8'hFF);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid",    {7'd0, out_valid}, 8'd0);
        chk("mid_rst_in_ready", {7'd0, in_ready},  8'd1);
        chk("mid_rst_pos",      {5'd0, out_pos},   8'd0);
        chk("mid_rst_last",     {7'd0, out_last},  8'd0);
        chk("mid_rst_cnt",      {4'd0, out_cnt},   8'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        push(3'd4, 1'b0, 1'b1, 4'd1);
        send(8'h10);
        drain();
        @(negedge clk);
        chk("end_idle_valid", {7'd0, out_valid}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
